// File: rtl/adder_pipe_pkg.sv
// Shared definitions for adder_pipe: operation encoding and saturation limits.
package adder_pipe_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int MAX_W = 64;

    // Largest positive two's-complement value of a w-bit word (0111..1).
    function automatic logic [MAX_W-1:0] sat_pos(input int w);
        sat_pos = {MAX_W{1'b1}} >> (MAX_W - w + 1);
    endfunction

    // Most negative two's-complement value of a w-bit word (1000..0).
    function automatic logic [MAX_W-1:0] sat_neg(input int w);
        sat_neg = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit slice adder; also reports the carry into its top bit for overflow detection.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s     = total[W-1:0];
    assign cout  = total[W];
    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
    assign cmsb  = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined carry-sliced adder/subtractor with valid/ready on both sides.
// Define ADDER_PIPE_SAT_EN to saturate the result on signed overflow instead of wrapping.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_cfg_err
        $error("adder_pipe: WIDTH must be a multiple of STAGES");
    end

    // Handshake: a beat moves on a side when valid && ready at the rising edge.
    // The whole pipeline advances together; it freezes only while the output
    // holds a beat that downstream refuses, so in_ready is simply "advancing".
    logic             adv;
    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ov_q, ov_d;

    logic [SW-1:0]     sa_w [STAGES];
    logic [SW-1:0]     sb_w [STAGES];
    logic [SW-1:0]     ss_w [STAGES];
    logic [STAGES-1:0] sci_w, sco_w, scm_w;
    logic              unused_cmsb;

    assign adv      = !(vld_q[LAST] && !out_ready);
    assign in_ready = adv;

    assign op      = sub ? OP_SUB : OP_ADD;
    assign b_eff   = (op == OP_SUB) ? ~b : b;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        if (k == 0) begin : g_first
            assign sa_w[k]  = a[SW-1:0];
            assign sb_w[k]  = b_eff[SW-1:0];
            assign sci_w[k] = cin_eff;
        end else begin : g_rest
            assign sa_w[k]  = a_q[k-1][k*SW +: SW];
            assign sb_w[k]  = b_q[k-1][k*SW +: SW];
            assign sci_w[k] = c_q[k-1];
        end

        adder_slice #(.W(SW)) u_slice (
            .a    (sa_w[k]),
            .b    (sb_w[k]),
            .cin  (sci_w[k]),
            .s    (ss_w[k]),
            .cout (sco_w[k]),
            .cmsb (scm_w[k])
        );
    end

    // Only the top slice's MSB carry matters for overflow.
    assign unused_cmsb = ^scm_w;

    always_comb begin
        vld_d = '0;
        c_d   = '0;
        vld_d[0]         = in_valid;
        a_d[0]           = a;
        b_d[0]           = b_eff;
        s_d[0]           = '0;
        s_d[0][SW-1:0]   = ss_w[0];
        c_d[0]           = sco_w[0];
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k]            = vld_q[k-1];
            a_d[k]              = a_q[k-1];
            b_d[k]              = b_q[k-1];
            s_d[k]              = s_q[k-1];
            s_d[k][k*SW +: SW]  = ss_w[k];
            c_d[k]              = sco_w[k];
        end
        ov_d = scm_w[LAST] ^ sco_w[LAST];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ov_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ov_q  <= ov_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign carry_out = c_q[LAST];
    assign overflow  = ov_q;

`ifdef ADDER_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_neg(WIDTH));

    // A wrapped result with the sign bit set means the true value overflowed upward.
    assign sum = !ov_q ? s_q[LAST] : (s_q[LAST][WIDTH-1] ? SAT_HI : SAT_LO);
`else
    assign sum = s_q[LAST];
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (WIDTH=16, STAGES=4) against a signed/unsigned arithmetic model.
module tb_adder_pipe;

    localparam int W = 16;
    localparam int S = 4;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W+1:0] exp_q [$];   // {carry_out, overflow, sum}
    int           age_q [$];   // advancing edges seen by each in-flight beat

    always #5 clock = ~clock;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Reference: true signed and unsigned results, then reduce to WIDTH bits.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        int sx, sy, si, ux, uy;
        logic co, ov;
        logic [W-1:0] r;
        sx = $signed(x);
        sy = $signed(y);
        ux = int'(x);
        uy = int'(y);
        if (s) begin
            si = sx - sy;
            co = (ux >= uy);
        end else begin
            si = sx + sy + int'(c);
            co = (ux + uy + int'(c)) > 65535;
        end
        ov = (si > 32767) || (si < -32768);
        r  = si[W-1:0];
`ifdef ADDER_PIPE_SAT_EN
        if (si > 32767) r = 16'h7FFF;
        else if (si < -32768) r = 16'h8000;
`endif
        return {co, ov, r};
    endfunction

    task automatic drive_beat(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic c, input logic s);
        in_valid = 1'b1;
        a   = x;
        b   = y;
        cin = c;
        sub = s;
    endtask

    task automatic test_reset();
        logic [W-1:0] x, y;
        logic [W+1:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            drive_beat(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clock);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
            n_vec++; if (sum !== '0) begin n_err++; $display("FAIL rst_sum: got %h want 0000", sum); end
            n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL rst_carry: got %b want 0", carry_out); end
            n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        x = 16'h1234;
        y = 16'h4321;
        exp = model(x, y, 1'b0, 1'b0);
        drive_beat(x, y, 1'b0, 1'b0);
        @(negedge clock);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL first_beat_ready: got %b want 1", in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= S; i++) begin
            @(negedge clock);
            n_vec++; if (out_valid !== (i == S)) begin n_err++; $display("FAIL first_beat_lat%0d: out_valid got %b want %b", i, out_valid, (i == S)); end
            if (i == S) begin
                n_vec++; if ({carry_out, overflow, sum} !== exp) begin n_err++; $display("FAIL first_beat_data: got %h want %h", {carry_out, overflow, sum}, exp); end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] va [8] = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h8000, 16'h00FF, 16'h0010, 16'h0000};
        logic [W-1:0] vb [8] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h8000, 16'h0000, 16'h0001, 16'h0000};
        logic         vc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic         vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W+1:0] exp;
        out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            exp = model(va[v], vb[v], vc[v], vs[v]);
            @(posedge clock); #1;
            drive_beat(va[v], vb[v], vc[v], vs[v]);
            @(negedge clock);
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arith%0d_ready: got %b want 1", v, in_ready); end
            @(posedge clock); #1;
            in_valid = 1'b0;
            for (int i = 1; i <= S; i++) begin
                @(negedge clock);
                n_vec++; if (out_valid !== (i == S)) begin n_err++; $display("FAIL arith%0d_lat%0d: out_valid got %b want %b", v, i, out_valid, (i == S)); end
                if (i == S) begin
                    n_vec++; if ({carry_out, overflow, sum} !== exp) begin n_err++; $display("FAIL arith%0d_data: got %h want %h", v, {carry_out, overflow, sum}, exp); end
                end
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic         exp_vld, exp_rdy, stall_prev;
        logic [W+1:0] got, held;
        exp_q.delete();
        age_q.delete();
        stall_prev = 1'b0;
        held = '0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clock); #1;
            if (c < 11) drive_beat(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            else if (c < 260) begin
                drive_beat(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                in_valid = ($urandom_range(0, 3) != 0);
            end else in_valid = 1'b0;
            if (c >= 5 && c < 8) out_ready = 1'b0;
            else if (c < 20 || c >= 260) out_ready = 1'b1;
            else out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            exp_vld = (age_q.size() > 0) && (age_q[0] == S);
            exp_rdy = !(exp_vld && !out_ready);
            got = {carry_out, overflow, sum};
            n_vec++; if (out_valid !== exp_vld) begin n_err++; $display("FAIL stream_valid c%0d: got %b want %b", c, out_valid, exp_vld); end
            n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL stream_ready c%0d: got %b want %b", c, in_ready, exp_rdy); end
            if (stall_prev) begin
                n_vec++; if (got !== held) begin n_err++; $display("FAIL stall_hold c%0d: got %h want %h", c, got, held); end
            end
            if (exp_vld) begin
                n_vec++; if (got !== exp_q[0]) begin n_err++; $display("FAIL stream_data c%0d: got %h want %h", c, got, exp_q[0]); end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(age_q.pop_front());
                end
            end
            stall_prev = exp_vld && !out_ready;
            held = got;
            if (in_valid && exp_rdy) begin
                exp_q.push_back(model(a, b, cin, sub));
                age_q.push_back(0);
            end
            if (exp_rdy) foreach (age_q[i]) age_q[i]++;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0] x, y;
        logic [W+1:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            drive_beat(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        reset_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        n_vec++; if ({carry_out, overflow, sum} !== '0) begin n_err++; $display("FAIL mid_rst_data: got %h want 0", {carry_out, overflow, sum}); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale%0d: out_valid got %b want 0", i, out_valid); end
            @(posedge clock); #1;
        end
        x = 16'hFFFF;
        y = 16'h0001;
        exp = model(x, y, 1'b0, 1'b0);
        drive_beat(x, y, 1'b0, 1'b0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= S; i++) begin
            @(negedge clock);
            n_vec++; if (out_valid !== (i == S)) begin n_err++; $display("FAIL mid_next_lat%0d: out_valid got %b want %b", i, out_valid, (i == S)); end
            if (i == S) begin
                n_vec++; if ({carry_out, overflow, sum} !== exp) begin n_err++; $display("FAIL mid_next_data: got %h want %h", {carry_out, overflow, sum}, exp); end
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        sub = 1'b0;
        #2 reset_n = 1'b0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
